// File: rtl/sort_arb_pkg.sv
// Shared types and constants for the sort_arbiter block: FSM state encoding,
// id-width helper and the default watchdog limit.
package sort_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester set in req, searching
// cyclically from last_grant+1. The caller owns the registered pointer.
module rr_arbiter
  import sort_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_req
);

  logic [ID_WIDTH-1:0] idx_s;
  logic                found_s;
  logic                take_s;

  // Rotating priority search; the winner is the first hit after last_grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx_s     = '0;
    found_s   = 1'b0;
    take_s    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s            = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      take_s           = req[idx_s] & ~found_s;
      grant[idx_s]     = take_s;
      grant_idx        = take_s ? idx_s : grant_idx;
      found_s          = found_s | take_s;
    end
    any_req = |req;
  end

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin front end sharing one sorter among NUM_REQ requesters.
// Optional watchdog on the sort is enabled by defining SORT_ARB_TIMEOUT_EN.
module sort_arbiter
  import sort_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LENGTH         = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ID_WIDTH      = id_width(NUM_REQ),
  localparam int VEC_W         = LENGTH * DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*VEC_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_order,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_WIDTH-1:0]        resp_id,
  output logic [VEC_W-1:0]           resp_data,
  output logic                       resp_err,
  output logic                       busy,
  output logic [VEC_W-1:0]           srt_data_in,
  output logic                       srt_sort_en,
  output logic                       srt_sort_order,
  input  logic [VEC_W-1:0]           srt_data_sorted,
  input  logic                       srt_sort_done
);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sort_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e          state_r;
  arb_state_e          next_state_s;
  logic [ID_WIDTH-1:0] last_grant_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic [ID_WIDTH-1:0] grant_idx_r;
  logic [VEC_W-1:0]    job_data_r;
  logic                job_order_r;
  logic [ID_WIDTH-1:0] resp_id_r;
  logic [VEC_W-1:0]    resp_data_r;
  logic                resp_err_r;
  logic [NUM_REQ-1:0]  arb_grant_s;
  logic [ID_WIDTH-1:0] arb_idx_s;
  logic                arb_any_s;
  logic                timeout_s;
  logic [VEC_W-1:0]    req_vec_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req_vec
    assign req_vec_s[i] = req_data[i*VEC_W +: VEC_W];
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .any_req    (arb_any_s)
  );

`ifdef SORT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Watchdog counts BUSY cycles; cleared while START so it begins at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r == START) begin
      to_cnt_r <= '0;
    end else if (state_r == BUSY && to_cnt_r != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Fires on the BUSY cycle in which the count reaches TIMEOUT_CYCLES.
  assign timeout_s = (state_r == BUSY) && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a completed sort wins over a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = arb_any_s ? GRANT : IDLE;
      GRANT:   next_state_s = START;
      START:   next_state_s = BUSY;
      BUSY: begin
        if (srt_sort_done || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP:    next_state_s = resp_ready ? IDLE : RESP;
      default: next_state_s = IDLE;
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    req_ready   = '0;
    srt_sort_en = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (state_r)
      IDLE:    busy        = 1'b0;
      GRANT:   req_ready   = grant_r;
      START:   srt_sort_en = 1'b1;
      BUSY:    busy        = 1'b1;
      RESP:    resp_valid  = 1'b1;
      default: busy        = 1'b0;
    endcase
  end

  // Grant capture, rotating pointer and job register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r      <= '0;
      grant_idx_r  <= '0;
      last_grant_r <= ID_WIDTH'(NUM_REQ - 1);
      job_data_r   <= '0;
      job_order_r  <= 1'b0;
    end else if (state_r == IDLE) begin
      grant_r      <= arb_grant_s;
      grant_idx_r  <= arb_idx_s;
    end else if (state_r == GRANT) begin
      last_grant_r <= grant_idx_r;
      job_data_r   <= req_vec_s[grant_idx_r];
      job_order_r  <= req_order[grant_idx_r];
    end else begin
      grant_r      <= grant_r;
    end
  end

  // Result capture; sorter done is only honoured while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id_r   <= '0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else if (state_r == BUSY && srt_sort_done) begin
      resp_id_r   <= grant_idx_r;
      resp_data_r <= srt_data_sorted;
      resp_err_r  <= 1'b0;
    end else if (timeout_s) begin
      resp_id_r   <= grant_idx_r;
      resp_data_r <= '0;
      resp_err_r  <= 1'b1;
    end else begin
      resp_err_r  <= resp_err_r;
    end
  end

  assign srt_data_in    = job_data_r;
  assign srt_sort_order = job_order_r;
  assign resp_id        = resp_id_r;
  assign resp_data      = resp_data_r;
  assign resp_err       = resp_err_r;

endmodule

// File: tb/tb_sort_arbiter.sv
// Self-checking bench for sort_arbiter with a behavioural sorter stub and a
// round-robin reference model; SORT_ARB_TIMEOUT_EN adds the watchdog test.
module tb_sort_arbiter;
  localparam int DW = 32;
  localparam int LEN = 8;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int VW = DW * LEN;
  localparam int IDW = 2;
  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*VW-1:0] req_data = '0;
  logic [NR-1:0] req_order = '0;
  logic resp_valid;
  logic resp_ready = 1'b0;
  logic [IDW-1:0] resp_id;
  vec_t resp_data;
  logic resp_err;
  logic busy;
  vec_t srt_data_in;
  logic srt_sort_en;
  logic srt_sort_order;
  vec_t srt_data_sorted;
  logic srt_sort_done;

  int total = 0;
  int bad = 0;
  int model_last = NR - 1;
  logic stub_on = 1'b1;
  int extra_req = 0;
  int extra_ack = 0;
  vec_t extra_data = '0;

  always #5 clk = ~clk;

  sort_arbiter #(.DATA_WIDTH(DW), .LENGTH(LEN), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_order(req_order), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .srt_data_in(srt_data_in),
    .srt_sort_en(srt_sort_en), .srt_sort_order(srt_sort_order),
    .srt_data_sorted(srt_data_sorted), .srt_sort_done(srt_sort_done)
  );

  function automatic vec_t sort_vec(input vec_t v, input logic desc);
    logic [DW-1:0] a [LEN];
    logic [DW-1:0] t;
    vec_t r;
    for (int i = 0; i < LEN; i++) a[i] = v[i*DW +: DW];
    for (int i = 0; i < LEN; i++)
      for (int j = 0; j < LEN - 1 - i; j++)
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < LEN; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  function automatic int model_pick(input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++)
      if (m[(model_last + k) % NR]) return (model_last + k) % NR;
    return -1;
  endfunction

  function automatic vec_t job_expect(input int id);
    return sort_vec(req_data[id*VW +: VW], req_order[id]);
  endfunction

  // Sorter stub: sorts whatever sits on srt_data_in when it finishes.
  initial begin
    int stub_cnt;
    stub_cnt = 0;
    srt_sort_done = 1'b0;
    srt_data_sorted = '0;
    forever begin
      @(posedge clk); #2;
      srt_sort_done = 1'b0;
      if (!rst_n) stub_cnt = 0;
      else if (extra_req != extra_ack) begin
        extra_ack = extra_req; srt_data_sorted = extra_data; srt_sort_done = 1'b1;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          srt_data_sorted = sort_vec(srt_data_in, srt_sort_order); srt_sort_done = 1'b1;
        end
      end else if (stub_on && srt_sort_en === 1'b1) stub_cnt = $urandom_range(1, 6);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reroll(input int id);
    for (int e = 0; e < LEN; e++) req_data[id*VW + e*DW +: DW] = $urandom;
    req_order[id] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, output bit ok, output int cyc);
    ok = 0; g = '0; cyc = 0;
    while (!ok && cyc < 40) begin
      tick(); cyc++;
      if (req_ready !== '0) begin g = req_ready; ok = 1; end
    end
  endtask

  task automatic wait_resp(output bit ok, output int cyc);
    ok = 0; cyc = 0;
    while (!ok && cyc < 200) begin
      tick(); cyc++;
      if (resp_valid === 1'b1) ok = 1;
    end
  endtask

  // One full job: grant, start pulse, result, optional stall, handshake.
  task automatic do_job(input int exp_id, input vec_t exp_vec, input int stall, input bit glitch,
                        input logic [NR-1:0] next_mask, input string tag, output int gcyc);
    logic [NR-1:0] g, want;
    logic [IDW-1:0] want_id;
    bit ok;
    int cyc;
    vec_t held;
    want = '0; want[exp_id] = 1'b1; want_id = exp_id[IDW-1:0];
    wait_grant(g, ok, gcyc);
    total++;
    if (!ok || g !== want) begin bad++; $display("FAIL %s grant: got %b want %b", tag, g, want); end
    model_last = exp_id;
    tick();
    total++;
    if (srt_sort_en !== 1'b1 || req_ready !== '0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s start: sort_en=%b ready=%b busy=%b want 1,0,1", tag, srt_sort_en, req_ready, busy);
    end
    req_valid = next_mask;
    reroll(exp_id);
    tick();
    total++;
    if (srt_sort_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL %s pulse: sort_en=%b busy=%b want 0,1", tag, srt_sort_en, busy);
    end
    wait_resp(ok, cyc);
    total++;
    if (!ok) begin bad++; $display("FAIL %s resp_wait: no resp_valid within %0d cycles", tag, cyc); end
    total++;
    if (resp_id !== want_id) begin bad++; $display("FAIL %s resp_id: got %0d want %0d", tag, resp_id, want_id); end
    total++;
    if (resp_data !== exp_vec) begin bad++; $display("FAIL %s resp_data: got %h want %h", tag, resp_data, exp_vec); end
    total++;
    if (resp_err !== 1'b0) begin bad++; $display("FAIL %s resp_err: got %b want 0", tag, resp_err); end
    held = resp_data;
    for (int s = 0; s < stall; s++) begin
      if (glitch && s == 1) begin extra_data = {VW/32{32'hDEAD_BEEF}}; extra_req++; end
      tick();
      total++;
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== '0 || resp_id !== want_id) begin
        bad++; $display("FAIL %s stall%0d: valid=%b id=%0d ready=%b data_changed=%b", tag, s,
                        resp_valid, resp_id, req_ready, resp_data !== held);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s idle: valid=%b busy=%b want 0,0", tag, resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b0 || srt_sort_en !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b en=%b want all 0", req_ready, resp_valid, busy, srt_sort_en);
    end
    total++;
    if (resp_id !== '0 || resp_data !== '0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_resp: id=%0d data=%h err=%b want 0", resp_id, resp_data, resp_err);
    end
    total++;
    if (srt_data_in !== '0 || srt_sort_order !== 1'b0) begin
      bad++; $display("FAIL reset_srt: data_in=%h order=%b want 0", srt_data_in, srt_sort_order);
    end
    rst_n = 1'b1;
    model_last = NR - 1;
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] vals [LEN];
    vec_t exp_vec;
    int gc;
    vals = '{32'd7, 32'd3, 32'd5, 32'd1, 32'd0, 32'd6, 32'd2, 32'd4};
    for (int e = 0; e < LEN; e++) begin
      req_data[2*VW + e*DW +: DW] = vals[e];
      exp_vec[e*DW +: DW] = DW'(e);
    end
    req_order[2] = 1'b0;
    req_valid = 4'b0100;
    do_job(2, exp_vec, 0, 1'b0, 4'b0000, "single", gc);
  endtask

  task automatic test_spurious_done();
    req_valid = '0;
    extra_data = {VW/32{32'h1234_5678}};
    extra_req++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
        bad++; $display("FAIL spurious%0d: valid=%b busy=%b ready=%b want 0", c, resp_valid, busy, req_ready);
      end
    end
  endtask

  task automatic test_resp_stall();
    int id, gc;
    req_valid = 4'b1010;
    id = model_pick(req_valid);
    do_job(id, job_expect(id), 10, 1'b1, 4'b1010, "stall", gc);
    id = model_pick(req_valid);
    do_job(id, job_expect(id), 0, 1'b0, 4'b0000, "after_stall", gc);
    total++;
    if (gc !== 1) begin bad++; $display("FAIL stall_regrant: grant after %0d cycles want 1", gc); end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    int gc;
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_last = NR - 1;
    for (int i = 0; i < NR; i++) reroll(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++)
      do_job(seq[k], job_expect(seq[k]), 0, 1'b0, (k == 4) ? 4'b0000 : 4'b1111, "rr", gc);
  endtask

  task automatic test_mid_reset();
    logic [NR-1:0] g;
    bit ok;
    int gc;
    reroll(2); req_order[2] = 1'b1;
    req_valid = 4'b0100;
    wait_grant(g, ok, gc);
    tick(); req_valid = '0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b0 || srt_sort_en !== 1'b0 ||
        srt_data_in !== '0 || srt_sort_order !== 1'b0 || resp_data !== '0 || resp_err !== 1'b0 || resp_id !== '0) begin
      bad++; $display("FAIL mid_reset: busy=%b order=%b data_in_nz=%b ready=%b want all 0",
                      busy, srt_sort_order, srt_data_in !== '0, req_ready);
    end
    tick(); tick();
    for (int i = 0; i < NR; i++) reroll(i);
    req_valid = 4'b1111;
    rst_n = 1'b1;
    model_last = NR - 1;
    do_job(0, job_expect(0), 0, 1'b0, 4'b0000, "post_reset", gc);
  endtask

  task automatic test_random();
    int id, gc;
    logic [NR-1:0] nxt;
    req_valid = NR'($urandom_range(1, 15));
    for (int n = 0; n < 20; n++) begin
      id = model_pick(req_valid);
      nxt = (n == 19) ? 4'b0000 : NR'($urandom_range(1, 15));
      do_job(id, job_expect(id), $urandom_range(0, 3), 1'($urandom_range(0, 1)), nxt, "random", gc);
    end
  endtask

`ifdef SORT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [NR-1:0] g;
    bit ok;
    int gc, n;
    stub_on = 1'b0;
    reroll(1);
    req_valid = 4'b0010;
    wait_grant(g, ok, gc);
    tick(); req_valid = '0;
    tick();
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin n++; tick(); end
    total++;
    if (n !== TO) begin bad++; $display("FAIL timeout_len: %0d busy cycles want %0d", n, TO); end
    total++;
    if (resp_err !== 1'b1 || resp_data !== '0 || resp_id !== 2'd1) begin
      bad++; $display("FAIL timeout_resp: err=%b id=%0d data_nz=%b want 1,1,0", resp_err, resp_id, resp_data !== '0);
    end
    extra_data = {VW/32{32'hCAFE_F00D}};
    extra_req++;
    tick(); tick();
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0) begin
      bad++; $display("FAIL late_done: valid=%b err=%b data_nz=%b want 1,1,0", resp_valid, resp_err, resp_data !== '0);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    stub_on = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_spurious_done();
    test_resp_stall();
    test_round_robin();
    test_mid_reset();
    test_random();
`ifdef SORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
